// File: rtl/i2c_reg_write_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_reg_write_master
// Brief    : I2C/SCCB master for single-register writes: START, addr+W, reg,
//            data, STOP, with an ACK check on every byte. Optional macro
//            I2C_CLK_STRETCH_EN lets a slave stretch SCL.
// Revision : 1.0
// ============================================================================
module i2c_reg_write_master #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned SCL_HZ    = 100_000,
  parameter logic [6:0]  DEV_ADDR7 = 7'h21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int unsigned QTR   = CLK_HZ / (4 * SCL_HZ);
  localparam int unsigned QW    = $clog2(QTR);
  localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BYTE  = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state;
  logic [QW-1:0] r_qcnt;
  logic [1:0]    r_qph;
  logic [2:0]    r_bit;
  logic [1:0]    r_byte_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_reg;
  logic [7:0]    r_data;
  logic [1:0]    r_sda_s;
  logic          w_hold;
  logic          w_qend;
  logic          w_scl_pull;
  logic          w_sda_pull;

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] r_scl_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_scl_s <= 2'b11;
    else        r_scl_s <= {r_scl_s[0], scl_i};
  end

  // Freeze the quarter counter at the start of q2 until SCL is really high.
  assign w_hold = (r_qph == 2'd2) && (r_qcnt == '0) && !r_scl_s[1] &&
                  ((r_state == S_BYTE) || (r_state == S_ACK) || (r_state == S_STOP));
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_hold       = 1'b0;
`endif

  assign w_qend = (r_qcnt == QLAST) && !w_hold;

  // Pad drive as a function of phase; registered below, so pads trail the
  // state by one clk uniformly and every relative edge ordering is kept.
  always_comb begin
    w_scl_pull = 1'b0;
    w_sda_pull = 1'b0;
    case (r_state)
      S_START: begin
        w_scl_pull = r_qph[1];
        w_sda_pull = 1'b1;
      end
      S_BYTE: begin
        w_scl_pull = ~r_qph[1];
        w_sda_pull = ~r_shift[7];
      end
      S_ACK: begin
        w_scl_pull = ~r_qph[1];
        w_sda_pull = 1'b0;
      end
      S_STOP: begin
        w_scl_pull = (r_qph == 2'd0);
        w_sda_pull = ~r_qph[1];
      end
      default: begin
        w_scl_pull = 1'b0;
        w_sda_pull = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_qcnt     <= '0;
      r_qph      <= 2'd0;
      r_bit      <= 3'd0;
      r_byte_idx <= 2'd0;
      r_shift    <= 8'h00;
      r_reg      <= 8'h00;
      r_data     <= 8'h00;
      r_sda_s    <= 2'b11;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      r_sda_s <= {r_sda_s[0], sda_i};
      scl_oe  <= w_scl_pull;
      sda_oe  <= w_sda_pull;
      done    <= 1'b0;

      if (busy && !w_hold) begin
        r_qcnt <= (r_qcnt == QLAST) ? '0 : r_qcnt + 1'b1;
      end
      if (busy && w_qend) begin
        r_qph <= r_qph + 2'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_shift    <= {DEV_ADDR7, 1'b0};
            r_reg      <= cmd_reg;
            r_data     <= cmd_data;
            r_byte_idx <= 2'd0;
            r_bit      <= 3'd0;
            r_qcnt     <= '0;
            r_qph      <= 2'd0;
            nack       <= 1'b0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_qend && (r_qph == 2'd3)) r_state <= S_BYTE;
        end

        S_BYTE: begin
          if (w_qend && (r_qph == 2'd3)) begin
            if (r_bit == 3'd7) begin
              r_state <= S_ACK;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {r_shift[6:0], 1'b0};
            end
          end
        end

        S_ACK: begin
          if (w_qend && (r_qph == 2'd2) && r_sda_s[1]) nack <= 1'b1;
          // nack can only be set by this byte: any earlier NACK already ended the frame.
          if (w_qend && (r_qph == 2'd3)) begin
            r_bit <= 3'd0;
            if (nack || (r_byte_idx == 2'd2)) begin
              r_state <= S_STOP;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_shift    <= (r_byte_idx == 2'd0) ? r_reg : r_data;
              r_state    <= S_BYTE;
            end
          end
        end

        S_STOP: begin
          if (w_qend && (r_qph == 2'd3)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_write_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_reg_write_master
// Brief    : Directed bench with an open-drain slave ACK model for
//            i2c_reg_write_master (stretch case under I2C_CLK_STRETCH_EN).
// Revision : 1.0
// ============================================================================
module tb_i2c_reg_write_master;

  localparam int CLK_HZ = 50_000_000;
  localparam int SCL_HZ = 1_000_000;
  localparam int QTR    = CLK_HZ / (4 * SCL_HZ);
`ifdef I2C_CLK_STRETCH_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, done, nack, scl_oe, sda_oe;
  logic       bfm_scl_pull = 1'b0;
  logic       bfm_sda_pull = 1'b0;
  logic       scl_line, sda_line;

  assign scl_line = ~(scl_oe | bfm_scl_pull);
  assign sda_line = ~(sda_oe | bfm_sda_pull);

  always #10 clk = ~clk;

  i2c_reg_write_master #(
    .CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ), .DEV_ADDR7(7'h21)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .busy(busy), .done(done), .nack(nack),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_line), .sda_i(sda_line)
  );

  // Slave model state
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [6:0] bfm_addr = 7'h21;
  int         bfm_nack_at = -1;
  bit         stretch_req = 1'b0;
  int         stretch_left = 0;
  bit         active = 1'b0, ack_phase = 1'b0, seen_rise = 1'b0, bfm_ack;
  int         bitcnt = 0, byte_no = 0, nbytes = 0, pulses = 0, starts = 0, stops = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] bytes_seen [8];
  longint     start_t [4];
  longint     stop_t [4];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    logic s, d;
    s = scl_line;
    d = sda_line;
    if (stretch_left > 0) begin
      stretch_left--;
      if (stretch_left == 0) bfm_scl_pull = 1'b0;
    end
    if (prev_scl && s && prev_sda && !d) begin
      if (starts < 4) start_t[starts] = $time;
      starts++;
      active = 1'b1; ack_phase = 1'b0; bitcnt = 0; byte_no = 0; seen_rise = 1'b0;
    end else if (prev_scl && s && !prev_sda && d) begin
      if (stops < 4) stop_t[stops] = $time;
      stops++;
      active = 1'b0;
      bfm_sda_pull = 1'b0;
    end else if (!prev_scl && s) begin
      seen_rise = 1'b1;
      if (active && !ack_phase && bitcnt < 8) begin
        shreg = {shreg[6:0], d};
        bitcnt++;
      end
    end else if (prev_scl && !s) begin
      if (seen_rise) pulses++;
      seen_rise = 1'b0;
      if (active && ack_phase) begin
        bfm_sda_pull = 1'b0;
        ack_phase = 1'b0;
        bitcnt = 0;
        byte_no++;
        if (stretch_req && byte_no == 3) begin
          bfm_scl_pull = 1'b1;
          stretch_left = 250;
          stretch_req = 1'b0;
        end
      end else if (active && bitcnt == 8) begin
        if (nbytes < 8) bytes_seen[nbytes] = shreg;
        nbytes++;
        if (byte_no == 0) bfm_ack = (shreg[7:1] == bfm_addr) && !shreg[0];
        else              bfm_ack = ((byte_no - 1) != bfm_nack_at);
        bfm_sda_pull = bfm_ack;
        ack_phase = 1'b1;
      end
    end
    prev_scl = s;
    prev_sda = d;
  end

  task automatic clr_bfm();
    nbytes = 0; pulses = 0; starts = 0; stops = 0;
  endtask

  task automatic wait_done(output bit to);
    int n;
    n = 0;
    to = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20000);
    if (!done) to = 1'b1;
  endtask

  // Issues one command; lat = clk edges from the accept edge through the done edge.
  task automatic run_cmd(input logic [7:0] r, input logic [7:0] d, input string tag,
                         output int lat);
    longint ta;
    bit     to;
    @(negedge clk);
    cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
    check({tag, "_ready_idle"}, cmd_ready, 1);
    @(posedge clk);
    ta = $time;
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready_busy"}, cmd_ready, 0);
    wait_done(to);
    check({tag, "_timeout"}, to, 0);
    lat = int'(($time - 10 - ta) / 20) + 1;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ready_after"}, cmd_ready, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  to;
    longint gap;

    // Reset values
    #15;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: full ACK write
    clr_bfm();
    run_cmd(8'h12, 8'h80, "t1", lat);
    check("t1_latency", lat, 116 * QTR + 1 + 27 * HOLD);
    check("t1_nack", nack, 0);
    check("t1_nbytes", nbytes, 3);
    check("t1_byte0", bytes_seen[0], 8'h42);
    check("t1_byte1", bytes_seen[1], 8'h12);
    check("t1_byte2", bytes_seen[2], 8'h80);
    check("t1_pulses", pulses, 27);
    check("t1_stops", stops, 1);

    // 2: address NACK
    clr_bfm();
    bfm_addr = 7'h30;
    run_cmd(8'h12, 8'h80, "t2", lat);
    check("t2_latency", lat, 44 * QTR + 1 + 9 * HOLD);
    check("t2_nack", nack, 1);
    check("t2_nbytes", nbytes, 1);
    check("t2_byte0", bytes_seen[0], 8'h42);
    check("t2_pulses", pulses, 9);
    check("t2_stops", stops, 1);
    bfm_addr = 7'h21;

    // 3: data byte NACK
    clr_bfm();
    bfm_nack_at = 1;
    run_cmd(8'h0A, 8'h3C, "t3", lat);
    check("t3_latency", lat, 116 * QTR + 1 + 27 * HOLD);
    check("t3_nack", nack, 1);
    check("t3_nbytes", nbytes, 3);
    check("t3_byte1", bytes_seen[1], 8'h0A);
    check("t3_byte2", bytes_seen[2], 8'h3C);
    check("t3_pulses", pulses, 27);
    check("t3_stops", stops, 1);
    bfm_nack_at = -1;

    // 4: back-to-back with cmd_valid held
    clr_bfm();
    @(negedge clk);
    cmd_reg = 8'h01; cmd_data = 8'hA5; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_reg = 8'h02; cmd_data = 8'h5A;
    wait_done(to);
    check("t4_timeout_a", to, 0);
    check("t4_nack_a", nack, 0);
    check("t4_ready_at_done", cmd_ready, 0);
    @(negedge clk);
    check("t4_ready_next", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("t4_busy_b", busy, 1);
    wait_done(to);
    check("t4_timeout_b", to, 0);
    check("t4_nack_b", nack, 0);
    repeat (4) @(negedge clk);
    check("t4_nbytes", nbytes, 6);
    check("t4_b0", bytes_seen[1], 8'h01);
    check("t4_b1", bytes_seen[2], 8'hA5);
    check("t4_b3", bytes_seen[3], 8'h42);
    check("t4_b4", bytes_seen[4], 8'h02);
    check("t4_b5", bytes_seen[5], 8'h5A);
    check("t4_starts", starts, 2);
    check("t4_stops", stops, 2);
    gap = (start_t[1] - stop_t[0]) / 20;
    check("t4_bus_free", gap >= 2 * QTR, 1);

    // 5: async reset during bit 4 of the register byte
    clr_bfm();
    @(negedge clk);
    cmd_reg = 8'h00; cmd_data = 8'h55; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (57 * QTR + QTR / 2 + 13 * HOLD - 1) @(posedge clk);
    #3;
    check("t5_pre_scl_oe", scl_oe, 1);
    check("t5_pre_sda_oe", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("t5_scl_oe", scl_oe, 0);
    check("t5_sda_oe", sda_oe, 0);
    check("t5_ready", cmd_ready, 1);
    check("t5_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_ready_rel", cmd_ready, 1);
    clr_bfm();
    run_cmd(8'h34, 8'h56, "t5r", lat);
    check("t5r_nack", nack, 0);
    check("t5r_byte1", bytes_seen[1], 8'h34);
    check("t5r_byte2", bytes_seen[2], 8'h56);

`ifdef I2C_CLK_STRETCH_EN
    // 6: slave stretches SCL for 250 clk after the third ACK
    clr_bfm();
    stretch_req = 1'b1;
    run_cmd(8'h11, 8'h22, "t6", lat);
    check("t6_lat_min", lat >= 116 * QTR + 1 + 27 * HOLD + 250 - 2 * QTR - 2, 1);
    check("t6_lat_max", lat <= 116 * QTR + 1 + 27 * HOLD + 250 - 2 * QTR + 8, 1);
    check("t6_nack", nack, 0);
    check("t6_byte1", bytes_seen[1], 8'h11);
    check("t6_byte2", bytes_seen[2], 8'h22);
    check("t6_stops", stops, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
